// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use/memory-hold controller for the 16-bit pipeline.
// Keeps a shadow of the EX/MEM and MEM/WB destinations and counts stall/forward cycles.
module forward_hazard_unit #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [REG_BITS-1:0] rs_id,
  input  logic [REG_BITS-1:0] rt_id,
  input  logic                use_rt_id,
  input  logic [REG_BITS-1:0] rs_ex,
  input  logic [REG_BITS-1:0] rt_ex,
  input  logic [REG_BITS-1:0] rd_ex,
  input  logic                reg_write_ex,
  input  logic                mem_read_ex,
  input  logic                mem_busy,
  input  logic                clear_counts,
  output logic [1:0]          forwardA,
  output logic [1:0]          forwardB,
  output logic                stall,
  output logic                freeze,
  output logic [CNT_BITS-1:0] stall_count,
  output logic [CNT_BITS-1:0] fwd_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [REG_BITS-1:0] exmemRd;
  logic [REG_BITS-1:0] memwbRd;
  logic                exmemWe;
  logic                memwbWe;
  logic                loadUse;
  logic                stallInt;
  logic                frozen;
  logic                anyForward;
  logic [1:0]          selA;
  logic [1:0]          selB;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic logic [1:0] forwardSel(
    input logic [REG_BITS-1:0] src,
    input logic [REG_BITS-1:0] exRd,
    input logic                exWe,
    input logic [REG_BITS-1:0] wbRd,
    input logic                wbWe
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exWe && (exRd != '0) && (exRd == src)) begin
      sel = 2'b10;
    end else if (wbWe && (wbRd != '0) && (wbRd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign selA       = forwardSel(rs_ex, exmemRd, exmemWe, memwbRd, memwbWe);
  assign selB       = forwardSel(rt_ex, exmemRd, exmemWe, memwbRd, memwbWe);
  assign anyForward = (selA != 2'b00) || (selB != 2'b00);
  assign frozen     = (state == FREEZE);

  assign loadUse = mem_read_ex && reg_write_ex && (rd_ex != '0) &&
                   ((rd_ex == rs_id) || (use_rt_id && (rd_ex == rt_id)));

  always_comb begin
    nextState = state;
    stallInt  = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          nextState = FREEZE;
        end else if (loadUse) begin
          stallInt  = 1'b1;
          nextState = BUBBLE;
        end
      end
      BUBBLE:  nextState = mem_busy ? FREEZE : RUN;
      FREEZE:  nextState = mem_busy ? FREEZE : RUN;
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // The shadow pipeline only advances when the real pipeline does.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      exmemRd <= '0;
      exmemWe <= 1'b0;
      memwbRd <= '0;
      memwbWe <= 1'b0;
    end else if (!frozen && !mem_busy) begin
      exmemRd <= rd_ex;
      exmemWe <= reg_write_ex;
      memwbRd <= exmemRd;
      memwbWe <= exmemWe;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || clear_counts) begin
      stall_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (stallInt && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_BITS'(1);
      end
      if (anyForward && !frozen && (fwd_count != '1)) begin
        fwd_count <= fwd_count + CNT_BITS'(1);
      end
    end
  end

  assign forwardA = reset_n ? selA : 2'b00;
  assign forwardB = reset_n ? selB : 2'b00;
  assign stall    = reset_n && stallInt;
  assign freeze   = reset_n && frozen;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed vector table, hand sequences for freeze,
// saturation and reset, then random stimulus against a behavioural model.
module tb_forward_hazard_unit;

  typedef struct {
    logic       resetN;
    logic [2:0] rsId;
    logic [2:0] rtId;
    logic       useRt;
    logic [2:0] rsEx;
    logic [2:0] rtEx;
    logic [2:0] rdEx;
    logic       regWrite;
    logic       memRead;
    logic       busy;
    logic       clear;
  } stimT;

  typedef struct {
    stimT       s;
    logic [1:0] fA;
    logic [1:0] fB;
    logic       st;
    logic       fr;
    int         sc;
    int         fc;
  } vecT;

  typedef struct {
    logic [2:0] rd;
    logic       we;
  } wrT;

  logic        clock = 1'b0;
  logic        resetN;
  logic [2:0]  rsId, rtId, rsEx, rtEx, rdEx;
  logic        useRtId, regWriteEx, memReadEx, memBusy, clearCounts;
  logic [1:0]  forwardA, forwardB;
  logic        stall, freeze;
  logic [15:0] stallCount, fwdCount;

  int errors = 0;
  int checks = 0;

  // Model: newest completed write first; freeze follows last cycle's mem_busy.
  wrT         hist[$];
  logic       mPrevBusy = 1'b0;
  logic       mStalledLast = 1'b0;
  int         mStallCnt = 0;
  int         mFwdCnt = 0;
  logic [1:0] mFA, mFB;
  logic       mStall, mFreeze;

  vecT tbl[15];

  always #5 clock = ~clock;

  forward_hazard_unit #(.REG_BITS(3), .CNT_BITS(16)) dut (
    .clock        (clock),
    .reset_n      (resetN),
    .rs_id        (rsId),
    .rt_id        (rtId),
    .use_rt_id    (useRtId),
    .rs_ex        (rsEx),
    .rt_ex        (rtEx),
    .rd_ex        (rdEx),
    .reg_write_ex (regWriteEx),
    .mem_read_ex  (memReadEx),
    .mem_busy     (memBusy),
    .clear_counts (clearCounts),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .stall        (stall),
    .freeze       (freeze),
    .stall_count  (stallCount),
    .fwd_count    (fwdCount)
  );

  function automatic stimT mk(input logic rn, input logic [2:0] a, input logic [2:0] b,
                              input logic u, input logic [2:0] c, input logic [2:0] d,
                              input logic [2:0] e, input logic rw, input logic mr,
                              input logic bz, input logic cl);
    stimT s;
    s.resetN = rn; s.rsId = a; s.rtId = b; s.useRt = u;
    s.rsEx = c; s.rtEx = d; s.rdEx = e;
    s.regWrite = rw; s.memRead = mr; s.busy = bz; s.clear = cl;
    return s;
  endfunction

  task automatic applyStimulus(input stimT s);
    resetN = s.resetN; rsId = s.rsId; rtId = s.rtId; useRtId = s.useRt;
    rsEx = s.rsEx; rtEx = s.rtEx; rdEx = s.rdEx;
    regWriteEx = s.regWrite; memReadEx = s.memRead;
    memBusy = s.busy; clearCounts = s.clear;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] modelFwd(input logic [2:0] src);
    for (int i = 0; i < hist.size(); i++) begin
      if (hist[i].we && hist[i].rd != 3'd0 && hist[i].rd == src)
        return (i == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic modelEval();
    logic hazard;
    hazard = memReadEx && regWriteEx && rdEx != 3'd0 &&
             (rdEx == rsId || (useRtId && rdEx == rtId));
    if (!resetN) begin
      mFA = 2'b00; mFB = 2'b00; mStall = 1'b0; mFreeze = 1'b0;
    end else begin
      mFA     = modelFwd(rsEx);
      mFB     = modelFwd(rtEx);
      mFreeze = mPrevBusy;
      mStall  = !memBusy && !mPrevBusy && !mStalledLast && hazard;
    end
  endtask

  task automatic modelUpdate();
    wrT w;
    if (!resetN) begin
      hist.delete();
      w.rd = 3'd0; w.we = 1'b0;
      hist.push_back(w);
      hist.push_back(w);
      mPrevBusy = 1'b0; mStalledLast = 1'b0;
      mStallCnt = 0; mFwdCnt = 0;
    end else begin
      if (!mFreeze && !memBusy) begin
        w.rd = rdEx; w.we = regWriteEx;
        hist.push_front(w);
        void'(hist.pop_back());
      end
      if (clearCounts) begin
        mStallCnt = 0; mFwdCnt = 0;
      end else begin
        if (mStall && mStallCnt < 65535) mStallCnt++;
        if ((mFA != 2'b00 || mFB != 2'b00) && !mFreeze && mFwdCnt < 65535) mFwdCnt++;
      end
      mStalledLast = mStall;
      mPrevBusy    = memBusy;
    end
  endtask

  task automatic startCycle(input stimT s);
    applyStimulus(s);
    #4;
    modelEval();
  endtask

  task automatic endCycle();
    @(posedge clock);
    modelUpdate();
    #1;
  endtask

  task automatic checkModel(input int n);
    checkOutput($sformatf("rnd%0d.forwardA", n), 32'(forwardA), 32'(mFA));
    checkOutput($sformatf("rnd%0d.forwardB", n), 32'(forwardB), 32'(mFB));
    checkOutput($sformatf("rnd%0d.stall", n), 32'(stall), 32'(mStall));
    checkOutput($sformatf("rnd%0d.freeze", n), 32'(freeze), 32'(mFreeze));
    checkOutput($sformatf("rnd%0d.stall_count", n), 32'(stallCount), mStallCnt);
    checkOutput($sformatf("rnd%0d.fwd_count", n), 32'(fwdCount), mFwdCnt);
  endtask

  initial begin
    stimT idle, s;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // resetN rsId rtId useRt rsEx rtEx rdEx rw mr busy clr | fA fB stall freeze sc fc
    tbl[0]  = '{mk(0, 0, 0, 0, 3, 0, 3, 1, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{mk(1, 0, 0, 0, 3, 0, 5, 1, 0, 0, 0), 2'b10, 2'b00, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{mk(1, 0, 0, 0, 3, 0, 5, 1, 0, 0, 0), 2'b01, 2'b00, 1'b0, 1'b0, 0, 1};
    tbl[4]  = '{mk(1, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0), 2'b00, 2'b10, 1'b0, 1'b0, 0, 2};
    tbl[5]  = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, 0, 3};
    tbl[6]  = '{mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0), 2'b00, 2'b00, 1'b1, 1'b0, 0, 3};
    tbl[7]  = '{mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, 1, 3};
    tbl[8]  = '{mk(1, 0, 2, 0, 0, 0, 2, 1, 1, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, 1, 3};
    tbl[9]  = '{mk(1, 0, 2, 1, 0, 0, 2, 1, 1, 0, 0), 2'b00, 2'b00, 1'b1, 1'b0, 1, 3};
    tbl[10] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0, 1'b0, 2, 3};
    tbl[11] = '{mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 1, 0), 2'b00, 2'b00, 1'b0, 1'b0, 2, 3};
    tbl[12] = '{mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 1, 0), 2'b00, 2'b00, 1'b0, 1'b1, 2, 3};
    tbl[13] = '{mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0), 2'b00, 2'b00, 1'b0, 1'b1, 2, 3};
    tbl[14] = '{mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0), 2'b00, 2'b00, 1'b1, 1'b0, 2, 3};

    for (int i = 0; i < 2; i++) begin
      startCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      endCycle();
    end

    for (int k = 0; k < 15; k++) begin
      startCycle(tbl[k].s);
      checkOutput($sformatf("row%0d.forwardA", k), 32'(forwardA), 32'(tbl[k].fA));
      checkOutput($sformatf("row%0d.forwardB", k), 32'(forwardB), 32'(tbl[k].fB));
      checkOutput($sformatf("row%0d.stall", k), 32'(stall), 32'(tbl[k].st));
      checkOutput($sformatf("row%0d.freeze", k), 32'(freeze), 32'(tbl[k].fr));
      checkOutput($sformatf("row%0d.stall_count", k), 32'(stallCount), tbl[k].sc);
      checkOutput($sformatf("row%0d.fwd_count", k), 32'(fwdCount), tbl[k].fc);
      endCycle();
    end

    // Memory freeze: busy for three cycles, shadow held, frozen forwards not counted.
    startCycle(idle);
    checkOutput("post.stall_count", 32'(stallCount), 3);
    checkOutput("post.stall_bubble", 32'(stall), 0);
    endCycle();
    startCycle(mk(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0)); endCycle();
    startCycle(mk(1, 0, 0, 0, 0, 0, 6, 1, 0, 1, 0));
    checkOutput("frz.c1.freeze", 32'(freeze), 0);
    endCycle();
    for (int i = 2; i <= 4; i++) begin
      startCycle(mk(1, 0, 0, 0, 4, 0, 6, 1, 0, (i < 4) ? 1'b1 : 1'b0, 0));
      checkOutput($sformatf("frz.c%0d.freeze", i), 32'(freeze), 1);
      checkOutput($sformatf("frz.c%0d.forwardA", i), 32'(forwardA), 32'(2'b10));
      endCycle();
    end
    startCycle(mk(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
    checkOutput("frz.c5.freeze", 32'(freeze), 0);
    checkOutput("frz.c5.forwardA", 32'(forwardA), 32'(2'b10));
    checkOutput("frz.c5.fwd_count", 32'(fwdCount), 3);
    endCycle();
    startCycle(mk(1, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0));
    checkOutput("frz.c6.forwardA", 32'(forwardA), 32'(2'b01));
    checkOutput("frz.c6.fwd_count", 32'(fwdCount), 4);
    endCycle();

    // Saturation of fwd_count, then clear concurrent with a forward.
    s = mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 65540; i++) begin
      startCycle(s);
      endCycle();
    end
    startCycle(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1));
    checkOutput("sat.fwd_count", 32'(fwdCount), 32'h0000FFFF);
    checkOutput("sat.forwardA", 32'(forwardA), 32'(2'b10));
    endCycle();
    startCycle(s);
    checkOutput("clr.fwd_count", 32'(fwdCount), 0);
    checkOutput("clr.stall_count", 32'(stallCount), 0);
    endCycle();

    // Reset while frozen clears state, shadow and counters.
    startCycle(mk(1, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0)); endCycle();
    startCycle(mk(1, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0)); endCycle();
    startCycle(mk(1, 0, 0, 0, 0, 0, 5, 1, 0, 1, 0));
    checkOutput("rst.pre.freeze", 32'(freeze), 1);
    endCycle();
    startCycle(mk(0, 2, 0, 0, 5, 5, 2, 1, 1, 1, 0));
    checkOutput("rst.low.forwardA", 32'(forwardA), 0);
    checkOutput("rst.low.stall", 32'(stall), 0);
    checkOutput("rst.low.freeze", 32'(freeze), 0);
    endCycle();
    startCycle(mk(1, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0));
    checkOutput("rst.after.forwardA", 32'(forwardA), 0);
    checkOutput("rst.after.forwardB", 32'(forwardB), 0);
    checkOutput("rst.after.freeze", 32'(freeze), 0);
    checkOutput("rst.after.stall_count", 32'(stallCount), 0);
    checkOutput("rst.after.fwd_count", 32'(fwdCount), 0);
    endCycle();
    startCycle(mk(1, 2, 0, 0, 0, 0, 2, 1, 1, 0, 0));
    checkOutput("rst.run.stall", 32'(stall), 1);
    endCycle();

    for (int n = 0; n < 1500; n++) begin
      s.resetN   = ($urandom_range(0, 59) != 0);
      s.rsId     = 3'($urandom_range(0, 3));
      s.rtId     = 3'($urandom_range(0, 3));
      s.useRt    = 1'($urandom_range(0, 1));
      s.rsEx     = 3'($urandom_range(0, 3));
      s.rtEx     = 3'($urandom_range(0, 3));
      s.rdEx     = 3'($urandom_range(0, 3));
      s.regWrite = ($urandom_range(0, 3) != 0);
      s.memRead  = 1'($urandom_range(0, 1));
      s.busy     = ($urandom_range(0, 4) == 0);
      s.clear    = ($urandom_range(0, 49) == 0);
      startCycle(s);
      checkModel(n);
      endCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
